// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: FSM states and funct3 opcodes.
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DSET  = 3'd2,
        S_DITER = 3'd3,
        S_DFIX  = 3'd4
    } md_state_e;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring unsigned radix-2 divider core: one quotient bit per step, XLEN steps per divide.
module div_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (start)
            cnt <= '0;
        else if (step)
            cnt <= cnt + CW'(1);
    end

    // A negative trial difference means the divisor did not fit: keep the shifted remainder.
    always_ff @(posedge clk) begin
        if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (step) begin
            if (diff[XLEN]) begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt == CW'(XLEN - 1));

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: pipelined multiplier plus iterative divider behind a valid/ready
// handshake, returning a tagged one-cycle writeback pulse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MUL_LAT   = 2,
    parameter int EARLY_DIV = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] x_rs1,
    input  logic [XLEN-1:0] x_rs2,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            busy,
    output logic            MD_vld,
    output logic [4:0]      MD_rd,
    output logic [XLEN-1:0] MD_x_rd
);

    localparam int PW = 2 * XLEN;
    localparam logic [XLEN-1:0] ONE  = XLEN'(1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [PW-1:0] mul_full(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b,
                                               input logic [2:0]      f);
        logic              sa;
        logic              sb;
        logic signed [PW-1:0] wa;
        logic signed [PW-1:0] wb;
        logic signed [PW-1:0] p;
        sa = ((f == MD_MULH) || (f == MD_MULHSU)) & a[XLEN-1];
        sb = (f == MD_MULH) & b[XLEN-1];
        wa = {{XLEN{sa}}, a};
        wb = {{XLEN{sb}}, b};
        p  = wa * wb;
        return p;
    endfunction

    function automatic logic [XLEN-1:0] mul_sel(input logic [PW-1:0] p, input logic [1:0] f);
        return (f == 2'b00) ? p[XLEN-1:0] : p[PW-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + ONE) : v;
    endfunction

    md_state_e       state;
    logic            accept;
    logic [XLEN-1:0] rs1_r;
    logic [XLEN-1:0] rs2_r;
    logic [1:0]      op_r;
    logic [4:0]      rd_r;
    logic [PW-1:0]   prod_p [MUL_LAT];
    logic [MUL_LAT-1:0] vld_p;

    logic            div_sgn;
    logic            neg1;
    logic            neg2;
    logic            div0;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] norm_res;
    logic [XLEN-1:0] div_res;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic            div_last;

    assign in_rdy = (state == S_IDLE);
    assign busy   = (state != S_IDLE);
    assign accept = in_vld & in_rdy & ~flush;

    // Sign handling works off the latched operands, which stay stable for the whole divide.
    always_comb begin
        div_sgn  = ~op_r[0];
        neg1     = div_sgn & rs1_r[XLEN-1];
        neg2     = div_sgn & rs2_r[XLEN-1];
        abs1     = neg_if(rs1_r, neg1);
        abs2     = neg_if(rs2_r, neg2);
        div0     = (rs2_r == '0);
        ovf      = div_sgn & (rs1_r == SMIN) & (rs2_r == '1);
        special  = div0 | ovf;
        if (div0)
            spec_res = op_r[1] ? rs1_r : '1;
        else
            spec_res = op_r[1] ? '0 : rs1_r;
        norm_res = op_r[1] ? neg_if(rem, neg1) : neg_if(quo, neg1 ^ neg2);
        div_res  = special ? spec_res : norm_res;
    end

    div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (state == S_DSET),
        .step     (state == S_DITER),
        .dividend (abs1),
        .divisor  (abs2),
        .quotient (quo),
        .remainder(rem),
        .last     (div_last)
    );

    // p0: product of the raw operands captured at accept; later stages just shift it along.
    always_ff @(posedge clk) begin
        if (accept) begin
            rs1_r     <= x_rs1;
            rs2_r     <= x_rs2;
            op_r      <= op[1:0];
            rd_r      <= rd;
            prod_p[0] <= mul_full(x_rs1, x_rs2, op);
        end
        for (int i = 1; i < MUL_LAT; i++)
            prod_p[i] <= prod_p[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            vld_p   <= '0;
            MD_vld  <= 1'b0;
            MD_rd   <= '0;
            MD_x_rd <= '0;
        end else if (flush) begin
            state  <= S_IDLE;
            vld_p  <= '0;
            MD_vld <= 1'b0;
        end else begin
            MD_vld <= 1'b0;
            vld_p  <= (vld_p << 1) | MUL_LAT'(accept & ~is_div(op));
            if (vld_p[MUL_LAT-1]) begin
                MD_vld  <= 1'b1;
                MD_rd   <= rd_r;
                MD_x_rd <= mul_sel(prod_p[MUL_LAT-1], op_r);
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_div(op))
                            state <= S_DSET;
                        else if (MUL_LAT > 1)
                            state <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (vld_p[MUL_LAT-1])
                        state <= S_IDLE;
                end
                S_DSET: begin
                    if ((EARLY_DIV != 0) && special) begin
                        MD_vld  <= 1'b1;
                        MD_rd   <= rd_r;
                        MD_x_rd <= spec_res;
                        state   <= S_IDLE;
                    end else begin
                        state <= S_DITER;
                    end
                end
                S_DITER: begin
                    if (div_last)
                        state <= S_DFIX;
                end
                S_DFIX: begin
                    MD_vld  <= 1'b1;
                    MD_rd   <= rd_r;
                    MD_x_rd <= div_res;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
